hspi_receiver_pkt: RTL and testbench

Receive-side endpoint of the team's HSPI packet link: accepts packets of one header word, PAYLOAD_LEN payload words and one CRC word on a 32-bit req/rdy/vld bus and streams the payload into a downstream FIFO. It checks header format, sequence continuity and CRC-32, and reports per-packet status. Used on the capture/loopback side of the DSI analyzer to receive and check what the transmitter emits.

---
 rtl/hspi_receiver_pkt.sv | 199 +++++++++++++++++++
 tb/tb_hspi_receiver_pkt.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hspi_receiver_pkt.sv
// hspi_receiver_pkt
//   Receive endpoint of the HSPI packet link. Accepts one header word,
//   PAYLOAD_LEN payload words and one CRC-32 word, streams the payload into a
//   downstream FIFO and reports per-packet status plus running counters.
//
// Ports
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   hrreq, hrvld, hrd       transmitter request, word valid, word data
//   hrrdy                   receiver ready
//   fifo_space              free words in the downstream FIFO
//   fifo_wr_en/_data        payload write strobe and word
//   pkt_done                one-cycle pulse per completed or aborted packet
//   pkt_crc_ok/_hdr_err/_seq_err/_abort/_seq   status, valid with pkt_done
//   pkt_ok_cnt/pkt_err_cnt  wrapping clean / errored packet counters
module hspi_receiver_pkt #(
  parameter int unsigned PAYLOAD_LEN = 1024,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        hrreq,
  output logic        hrrdy,
  input  logic        hrvld,
  input  logic [31:0] hrd,
  input  logic [15:0] fifo_space,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data,
  output logic        pkt_done,
  output logic        pkt_crc_ok,
  output logic        pkt_hdr_err,
  output logic        pkt_seq_err,
  output logic        pkt_abort,
  output logic [3:0]  pkt_seq,
  output logic [15:0] pkt_ok_cnt,
  output logic [15:0] pkt_err_cnt
);

  localparam int unsigned CW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(PAYLOAD_LEN - 1);
  localparam logic [TW-1:0] LAST_IDLE = TW'(TIMEOUT_CYC - 1);
  localparam logic [25:0]   HDR_MAGIC = 26'h0a5a5a5;
  localparam logic [31:0]   CRC_POLY  = 32'h04C11DB7;

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CRC, DONE} state_t;

  function automatic logic [31:0] bitrev32(input logic [31:0] d);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) r[i] = d[31 - i];
    return r;
  endfunction

  // MSB-first CRC-32 over one 32-bit word.
  function automatic logic [31:0] crc32_32b(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int unsigned i = 0; i < 32; i++) begin
      fb = c[31] ^ data[31 - i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

  state_t          state;
  logic            hrreq_q, hrvld_q;
  logic [31:0]     hrd_q;
  logic [31:0]     crc_reg;
  logic [CW-1:0]   word_cnt;
  logic [TW-1:0]   idle_cnt;
  logic [3:0]      expected_seq, seq_r;
  logic            hdr_err_r, seq_err_r;
  logic            wr_pend;
  logic [31:0]     wr_data_pend;
  // Completion pipeline: decision -> stage 2 -> pkt_done (CRC settle + compare).
  logic            fin1, fin2;
  logic            fin_crc_ok1, fin_crc_ok2, fin_abort1, fin_abort2;
  logic            timeout, crc_match;

  assign timeout   = !hrvld_q && (idle_cnt == LAST_IDLE);
  assign crc_match = (hrd_q == ~bitrev32(crc_reg));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      hrreq_q      <= 1'b0;
      hrvld_q      <= 1'b0;
      hrd_q        <= '0;
      crc_reg      <= '1;
      word_cnt     <= '0;
      idle_cnt     <= '0;
      expected_seq <= '0;
      seq_r        <= '0;
      hdr_err_r    <= 1'b0;
      seq_err_r    <= 1'b0;
      wr_pend      <= 1'b0;
      wr_data_pend <= '0;
      fin1         <= 1'b0;
      fin2         <= 1'b0;
      fin_crc_ok1  <= 1'b0;
      fin_crc_ok2  <= 1'b0;
      fin_abort1   <= 1'b0;
      fin_abort2   <= 1'b0;
      hrrdy        <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      pkt_done     <= 1'b0;
      pkt_crc_ok   <= 1'b0;
      pkt_hdr_err  <= 1'b0;
      pkt_seq_err  <= 1'b0;
      pkt_abort    <= 1'b0;
      pkt_seq      <= '0;
      pkt_ok_cnt   <= '0;
      pkt_err_cnt  <= '0;
    end else begin
      hrreq_q <= hrreq;
      hrvld_q <= hrvld;
      hrd_q   <= hrd;

      wr_pend      <= 1'b0;
      fifo_wr_en   <= wr_pend;
      fifo_wr_data <= wr_data_pend;

      fin1        <= 1'b0;
      fin2        <= fin1;
      fin_crc_ok2 <= fin_crc_ok1;
      fin_abort2  <= fin_abort1;
      pkt_done    <= fin2;

      if (fin2) begin
        hrrdy       <= 1'b0;
        pkt_crc_ok  <= fin_crc_ok2;
        pkt_abort   <= fin_abort2;
        pkt_hdr_err <= hdr_err_r;
        pkt_seq_err <= seq_err_r;
        pkt_seq     <= seq_r;
        // Resync to the received seq even after a seq error; aborts leave it alone.
        if (!fin_abort2) expected_seq <= seq_r + 4'd1;
        if (fin_crc_ok2 && !hdr_err_r && !seq_err_r && !fin_abort2)
          pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
        else
          pkt_err_cnt <= pkt_err_cnt + 16'd1;
      end

      unique case (state)
        IDLE: begin
          crc_reg  <= '1;
          word_cnt <= '0;
          idle_cnt <= '0;
          if (hrreq_q && (32'(fifo_space) >= PAYLOAD_LEN)) begin
            state     <= HEADER;
            hrrdy     <= 1'b1;
            hdr_err_r <= 1'b0;
            seq_err_r <= 1'b0;
            seq_r     <= '0;
          end
        end
        HEADER, PAYLOAD, CRC: begin
          idle_cnt <= hrvld_q ? '0 : idle_cnt + 1'b1;
          // A CRC word arriving together with the hrreq drop still completes.
          if (state == CRC && hrvld_q) begin
            fin1        <= 1'b1;
            fin_crc_ok1 <= crc_match;
            fin_abort1  <= 1'b0;
            state       <= DONE;
          end else if (!hrreq_q || timeout) begin
            fin1        <= 1'b1;
            fin_crc_ok1 <= 1'b0;
            fin_abort1  <= 1'b1;
            state       <= DONE;
          end else if (hrvld_q) begin
            crc_reg <= crc32_32b(crc_reg, bitrev32(hrd_q));
            if (state == HEADER) begin
              hdr_err_r <= (hrd_q[31:30] != 2'b11) || (hrd_q[25:0] != HDR_MAGIC);
              seq_err_r <= (hrd_q[29:26] != expected_seq);
              seq_r     <= hrd_q[29:26];
              state     <= PAYLOAD;
            end else begin
              wr_pend      <= 1'b1;
              wr_data_pend <= hrd_q;
              if (word_cnt == LAST_WORD) begin
                word_cnt <= '0;
                state    <= CRC;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end
          end
        end
        DONE: begin
          // Hold until the status has been published so hrrdy cannot re-rise early.
          if (!hrreq_q && !fin1 && !fin2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hspi_receiver_pkt.sv
// Testbench for hspi_receiver_pkt: drives packets through the HSPI bus,
// scoreboards the FIFO payload stream and checks per-packet status.
module tb_hspi_receiver_pkt;

  localparam int PLEN = 1024;
  localparam int TOUT = 4096;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        hrreq, hrrdy, hrvld;
  logic [31:0] hrd;
  logic [15:0] fifo_space;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        pkt_done, pkt_crc_ok, pkt_hdr_err, pkt_seq_err, pkt_abort;
  logic [3:0]  pkt_seq;
  logic [15:0] pkt_ok_cnt, pkt_err_cnt;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  m_exp_seq = '0;
  logic [15:0] m_ok = '0;
  logic [15:0] m_err = '0;

  hspi_receiver_pkt #(.PAYLOAD_LEN(PLEN), .TIMEOUT_CYC(TOUT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .hrreq(hrreq), .hrrdy(hrrdy),
    .hrvld(hrvld), .hrd(hrd), .fifo_space(fifo_space),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .pkt_done(pkt_done), .pkt_crc_ok(pkt_crc_ok), .pkt_hdr_err(pkt_hdr_err),
    .pkt_seq_err(pkt_seq_err), .pkt_abort(pkt_abort), .pkt_seq(pkt_seq),
    .pkt_ok_cnt(pkt_ok_cnt), .pkt_err_cnt(pkt_err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout got still running required finish");
    $fatal(1);
  end

  // Scoreboard consumer: every FIFO write must match the next pushed word.
  always @(negedge sys_clk) begin : monitor
    logic [31:0] exp_w;
    if (!sys_rst && fifo_wr_en === 1'b1) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fifo_extra_write got %h required no write", fifo_wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (fifo_wr_data !== exp_w) begin
          errors++;
          $display("FAIL fifo_data got %h required %h", fifo_wr_data, exp_w);
        end
      end
    end
  end

  // Reflected (LSB-first) CRC-32, 0xEDB88320.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    logic        b;
    r = c;
    for (int i = 0; i < 32; i++) begin
      b = r[0] ^ w[i];
      r = (r >> 1) ^ (b ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [31:0] mk_hdr(input logic [3:0] s);
    return {2'b11, s, 26'h0a5a5a5};
  endfunction

  // {crc_ok, hdr_err, seq_err, abort, seq}
  function automatic logic [7:0] exp_status(input logic [31:0] h, input bit crc_good, input bit abort);
    logic he, se;
    he = (h[31:30] != 2'b11) || (h[25:0] != 26'h0a5a5a5);
    se = (h[29:26] != m_exp_seq);
    return {crc_good && !abort, he, se, abort, h[29:26]};
  endfunction

  function automatic logic [7:0] status_now();
    return {pkt_crc_ok, pkt_hdr_err, pkt_seq_err, pkt_abort, pkt_seq};
  endfunction

  task automatic model_commit(input logic [7:0] st);
    if (!st[4]) m_exp_seq = st[3:0] + 4'd1;
    if (st[7] && !st[6] && !st[5] && !st[4]) m_ok++;
    else m_err++;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Sends one packet; returns early (mid-packet) at drop_at or stall_at.
  task automatic send_pkt(input logic [31:0] h, input int flip_at, input int drop_at,
                          input int stall_at, input bit drop_with_crc, output int rdy_wait);
    logic [31:0] c, w;
    hrreq = 1'b1;
    rdy_wait = 0;
    while (hrrdy !== 1'b1 && rdy_wait < 100) begin
      tick();
      rdy_wait++;
    end
    if (hrrdy !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout got hrrdy=%b required 1", hrrdy);
      hrreq = 1'b0;
      return;
    end
    c = '1;
    hrd = h;
    hrvld = 1'b1;
    c = crc_upd(c, h);
    tick();
    for (int i = 0; i < PLEN; i++) begin
      if (i == drop_at) begin
        hrreq = 1'b0;
        hrvld = 1'b0;
        return;
      end
      if (i == stall_at) begin
        hrvld = 1'b0;
        return;
      end
      w = 32'd1 << (i % 32);
      c = crc_upd(c, w);
      if (i == flip_at) w = w ^ 32'd1;
      exp_q.push_back(w);
      hrd = w;
      hrvld = 1'b1;
      tick();
    end
    hrd = ~c;
    hrvld = 1'b1;
    if (drop_with_crc) hrreq = 1'b0;
    tick();
    hrvld = 1'b0;
    hrreq = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (pkt_done !== 1'b1 && n < 6000);
    if (pkt_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL pkt_done_timeout got no pulse required pulse within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({hrrdy, fifo_wr_en, fifo_wr_data, pkt_done, pkt_crc_ok, pkt_hdr_err, pkt_seq_err,
         pkt_abort, pkt_seq, pkt_ok_cnt, pkt_err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b wr=%b data=%h done=%b st=%h ok=%0d err=%0d required all 0",
               hrrdy, fifo_wr_en, fifo_wr_data, pkt_done, status_now(), pkt_ok_cnt, pkt_err_cnt);
    end
  endtask

  task automatic test_clean();
    logic [31:0] h;
    logic [7:0]  st;
    int rw, n;
    h = 32'hC0A5A5A5;
    st = exp_status(h, 1'b1, 1'b0);
    wr_count = 0;
    send_pkt(h, -1, -1, -1, 1'b0, rw);
    checks++;
    if (rw != 2) begin errors++; $display("FAIL rdy_latency got %0d required 2", rw); end
    wait_done(n);
    checks++;
    if (n != 4) begin errors++; $display("FAIL done_latency got %0d required 4", n); end
    checks++;
    if (hrrdy !== 1'b0) begin errors++; $display("FAIL rdy_fall got %b required 0", hrrdy); end
    checks++;
    if (status_now() !== st) begin errors++; $display("FAIL clean_status got %h required %h", status_now(), st); end
    model_commit(st);
    checks++;
    if ({pkt_ok_cnt, pkt_err_cnt} !== {m_ok, m_err}) begin
      errors++; $display("FAIL clean_counters got %0d/%0d required %0d/%0d", pkt_ok_cnt, pkt_err_cnt, m_ok, m_err);
    end
    tick();
    checks++;
    if (pkt_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b required 0", pkt_done); end
    repeat (3) tick();
    checks++;
    if (wr_count != PLEN || exp_q.size() != 0) begin
      errors++; $display("FAIL clean_writes got %0d left %0d required %0d left 0", wr_count, exp_q.size(), PLEN);
    end
  endtask

  task automatic test_crc_err();
    logic [31:0] h;
    logic [7:0]  st;
    int rw, n;
    h = mk_hdr(m_exp_seq);
    st = exp_status(h, 1'b0, 1'b0);
    wr_count = 0;
    send_pkt(h, 500, -1, -1, 1'b0, rw);
    wait_done(n);
    checks++;
    if (status_now() !== st) begin errors++; $display("FAIL crc_err_status got %h required %h", status_now(), st); end
    model_commit(st);
    checks++;
    if ({pkt_ok_cnt, pkt_err_cnt} !== {m_ok, m_err}) begin
      errors++; $display("FAIL crc_err_counters got %0d/%0d required %0d/%0d", pkt_ok_cnt, pkt_err_cnt, m_ok, m_err);
    end
    repeat (4) tick();
    checks++;
    if (wr_count != PLEN) begin errors++; $display("FAIL crc_err_writes got %0d required %0d", wr_count, PLEN); end
  endtask

  task automatic test_seq_resync();
    logic [31:0] hdrs[3];
    logic [7:0]  st;
    int rw, n;
    hdrs = '{32'hC0A5A5A5, 32'hC8A5A5A5, 32'hCCA5A5A5};
    // Reset in the middle of a packet must clear everything, including expected seq.
    send_pkt(mk_hdr(m_exp_seq), -1, -1, 50, 1'b0, rw);
    repeat (3) tick();
    sys_rst = 1'b1;
    hrreq = 1'b0;
    #2;
    test_reset();
    tick();
    sys_rst = 1'b0;
    exp_q.delete();
    m_exp_seq = '0;
    m_ok = '0;
    m_err = '0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      st = exp_status(hdrs[i], 1'b1, 1'b0);
      wr_count = 0;
      send_pkt(hdrs[i], -1, -1, -1, (i == 2), rw);
      wait_done(n);
      checks++;
      if (status_now() !== st) begin errors++; $display("FAIL seq_status_%0d got %h required %h", i, status_now(), st); end
      model_commit(st);
      checks++;
      if ({pkt_ok_cnt, pkt_err_cnt} !== {m_ok, m_err}) begin
        errors++; $display("FAIL seq_counters_%0d got %0d/%0d required %0d/%0d", i, pkt_ok_cnt, pkt_err_cnt, m_ok, m_err);
      end
      repeat (4) tick();
      checks++;
      if (wr_count != PLEN) begin errors++; $display("FAIL seq_writes_%0d got %0d required %0d", i, wr_count, PLEN); end
    end
  endtask

  task automatic test_hdr_err();
    logic [31:0] h;
    logic [7:0]  st;
    int rw, n;
    h = 32'h40A5A5A5;
    st = exp_status(h, 1'b1, 1'b0);
    wr_count = 0;
    send_pkt(h, -1, -1, -1, 1'b0, rw);
    wait_done(n);
    checks++;
    if (status_now() !== st) begin errors++; $display("FAIL hdr_err_status got %h required %h", status_now(), st); end
    model_commit(st);
    checks++;
    if ({pkt_ok_cnt, pkt_err_cnt} !== {m_ok, m_err}) begin
      errors++; $display("FAIL hdr_err_counters got %0d/%0d required %0d/%0d", pkt_ok_cnt, pkt_err_cnt, m_ok, m_err);
    end
    repeat (4) tick();
    checks++;
    if (wr_count != PLEN) begin errors++; $display("FAIL hdr_err_writes got %0d required %0d", wr_count, PLEN); end
  endtask

  task automatic test_abort_drop();
    logic [31:0] h;
    logic [7:0]  st;
    int rw, n;
    h = mk_hdr(m_exp_seq);
    st = exp_status(h, 1'b0, 1'b1);
    wr_count = 0;
    send_pkt(h, -1, 100, -1, 1'b0, rw);
    wait_done(n);
    checks++;
    if (status_now() !== st) begin errors++; $display("FAIL drop_status got %h required %h", status_now(), st); end
    model_commit(st);
    checks++;
    if ({pkt_ok_cnt, pkt_err_cnt} !== {m_ok, m_err}) begin
      errors++; $display("FAIL drop_counters got %0d/%0d required %0d/%0d", pkt_ok_cnt, pkt_err_cnt, m_ok, m_err);
    end
    repeat (4) tick();
    checks++;
    if (wr_count != 100 || exp_q.size() != 0 || hrrdy !== 1'b0) begin
      errors++; $display("FAIL drop_writes got %0d rdy=%b required 100 rdy=0", wr_count, hrrdy);
    end
  endtask

  task automatic test_abort_stall();
    logic [31:0] h;
    logic [7:0]  st;
    int rw, n;
    h = mk_hdr(m_exp_seq);
    st = exp_status(h, 1'b0, 1'b1);
    wr_count = 0;
    send_pkt(h, -1, -1, 10, 1'b0, rw);
    wait_done(n);
    checks++;
    if (status_now() !== st) begin errors++; $display("FAIL stall_status got %h required %h", status_now(), st); end
    model_commit(st);
    checks++;
    if ({pkt_ok_cnt, pkt_err_cnt} !== {m_ok, m_err}) begin
      errors++; $display("FAIL stall_counters got %0d/%0d required %0d/%0d", pkt_ok_cnt, pkt_err_cnt, m_ok, m_err);
    end
    hrreq = 1'b0;
    repeat (4) tick();
    checks++;
    if (wr_count != 10 || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_writes got %0d required 10", wr_count);
    end
  endtask

  task automatic test_fifo_space();
    logic [31:0] h;
    logic [7:0]  st;
    int rw, n;
    fifo_space = 16'd1023;
    hrreq = 1'b1;
    repeat (10) tick();
    checks++;
    if (hrrdy !== 1'b0) begin errors++; $display("FAIL space_low_rdy got %b required 0", hrrdy); end
    fifo_space = 16'd1024;
    repeat (2) tick();
    checks++;
    if (hrrdy !== 1'b1) begin errors++; $display("FAIL space_ok_rdy got %b required 1", hrrdy); end
    h = mk_hdr(m_exp_seq);
    st = exp_status(h, 1'b1, 1'b0);
    wr_count = 0;
    send_pkt(h, -1, -1, -1, 1'b0, rw);
    wait_done(n);
    checks++;
    if (status_now() !== st) begin errors++; $display("FAIL space_status got %h required %h", status_now(), st); end
    model_commit(st);
    checks++;
    if ({pkt_ok_cnt, pkt_err_cnt} !== {m_ok, m_err}) begin
      errors++; $display("FAIL space_counters got %0d/%0d required %0d/%0d", pkt_ok_cnt, pkt_err_cnt, m_ok, m_err);
    end
    repeat (4) tick();
    checks++;
    if (wr_count != PLEN || exp_q.size() != 0) begin
      errors++; $display("FAIL space_writes got %0d left %0d required %0d left 0", wr_count, exp_q.size(), PLEN);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    hrreq = 1'b0;
    hrvld = 1'b0;
    hrd = '0;
    fifo_space = 16'd1024;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
    test_reset();
    test_clean();
    test_crc_err();
    test_seq_resync();
    test_hdr_err();
    test_abort_drop();
    test_abort_stall();
    test_fifo_space();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
